// File: rtl/decode_pkg.sv
// Shared definitions for the immediate-decode stage: opcodes, immediate
// formats, ALU control codes and the decoded-instruction record.
package decode_pkg;

  // Widest supported datapath; narrower stages use the low XLEN bits.
  localparam int XLEN_MAX     = 64;
  localparam int ALU_CODE_W   = 5;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_U    = 3'd1,
    FMT_J    = 3'd2,
    FMT_I    = 3'd3,
    FMT_S    = 3'd4,
    FMT_B    = 3'd5
  } imm_fmt_e;

  // ALU control codes shared with the execute stage.
  localparam logic [ALU_CODE_W-1:0] ALU_NOP = 5'd0;
  localparam logic [ALU_CODE_W-1:0] LUI     = 5'd16;
  localparam logic [ALU_CODE_W-1:0] AUIPC   = 5'd17;

  // Decoded record sized for XLEN_MAX; imm is sign-extended over all
  // XLEN_MAX bits and pc is zero-extended, so slicing [XLEN-1:0] yields
  // the correct value for any legal XLEN.
  typedef struct packed {
    logic [4:0]            rd;
    logic [XLEN_MAX-1:0]   imm;
    imm_fmt_e              fmt;
    logic [ALU_CODE_W-1:0] alu_control;
    logic                  illegal;
    logic [XLEN_MAX-1:0]   pc;
  } dec_instr_t;

  localparam dec_instr_t DEC_RST = '{
    rd:          5'd0,
    imm:         '0,
    fmt:         FMT_NONE,
    alu_control: ALU_NOP,
    illegal:     1'b0,
    pc:          '0
  };

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational decode of one instruction word into a dec_instr_t.
module imm_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [XLEN_MAX-1:0] pc,
  output dec_instr_t          dec
);

  logic sgn;
  assign sgn = instr[31];

  // Opcode-driven format/immediate/rd selection; unknown opcodes (which
  // include every word whose low two bits are not 2'b11) decode as illegal.
  always_comb begin
    dec    = DEC_RST;
    dec.pc = pc;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt         = FMT_U;
        dec.rd          = instr[11:7];
        dec.imm         = {{32{sgn}}, instr[31:12], 12'b0};
        dec.alu_control = (instr[6:0] == OPC_LUI) ? LUI : AUIPC;
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        dec.rd  = instr[11:7];
        dec.imm = {{44{sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        dec.fmt = FMT_I;
        dec.rd  = instr[11:7];
        dec.imm = {{52{sgn}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = {{52{sgn}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = {{52{sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Registered immediate-decode stage with valid/ready handshake and a
// two-entry (output + skid) buffer so in_ready is a pure register output.
module decode_imm_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [2:0]            out_fmt,
  output logic [ALU_CTRL_W-1:0] out_alu_control,
  output logic                  out_illegal,
  output logic [XLEN-1:0]       out_pc
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} occ_e;

  occ_e                state;
  logic                in_ready_q;
  logic                out_valid_q;
  dec_instr_t          out_q;
  dec_instr_t          skid_q;
  dec_instr_t          dec_in;
  logic [XLEN_MAX-1:0] pc_ext;
  logic                acc;
  logic                pop;

  // Zero-extend the PC into the wide record field.
  always_comb begin
    pc_ext            = '0;
    pc_ext[XLEN-1:0]  = in_pc;
  end

  imm_decode_comb u_dec (
    .instr (in_instr),
    .pc    (pc_ext),
    .dec   (dec_in)
  );

  assign acc = in_valid && in_ready_q;
  assign pop = out_valid_q && out_ready;

  // Occupancy FSM; flush outranks everything and drops any same-cycle input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= DEC_RST;
      skid_q      <= DEC_RST;
    end else if (flush) begin
      state       <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            out_q       <= dec_in;
            out_valid_q <= 1'b1;
            state       <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && !pop) begin
            skid_q     <= dec_in;
            in_ready_q <= 1'b0;
            state      <= S_FULL;
          end else if (acc) begin
            out_q <= dec_in;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state       <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          state       <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_rd          = out_q.rd;
  assign out_imm         = out_q.imm[XLEN-1:0];
  assign out_fmt         = out_q.fmt;
  assign out_alu_control = ALU_CTRL_W'(out_q.alu_control);
  assign out_illegal     = out_q.illegal;
  assign out_pc          = out_q.pc[XLEN-1:0];

  // Upper record bits are redundant extension bits when XLEN is narrow.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.imm[XLEN_MAX-1:XLEN], out_q.pc[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage at XLEN=32 and XLEN=64.
module tb_decode_imm_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [4:0]  out_rd, out_alu_control;
  logic [2:0]  out_fmt;

  logic        flush64, in_valid64, out_ready64;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_instr64;
  logic [63:0] in_pc64, out_imm64, out_pc64;
  logic [4:0]  out_rd64, out_alu_control64;
  logic [2:0]  out_fmt64;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  decode_imm_stage #(.XLEN(32), .ALU_CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_alu_control(out_alu_control), .out_illegal(out_illegal),
    .out_pc(out_pc)
  );

  decode_imm_stage #(.XLEN(64), .ALU_CTRL_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_rd(out_rd64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_alu_control(out_alu_control64), .out_illegal(out_illegal64),
    .out_pc(out_pc64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
    in_instr64 = '0; in_pc64 = '0;
    step(); step();

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'(FMT_NONE));
    chk("rst_alu", 64'(out_alu_control), 64'(ALU_NOP));
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1;

    // LUI x1, 0x12345
    present(32'h123450B7, 32'h100); step();
    chk("lui_valid", 64'(out_valid), 64'd1);
    chk("lui_rd", 64'(out_rd), 64'd1);
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    chk("lui_fmt", 64'(out_fmt), 64'(FMT_U));
    chk("lui_alu", 64'(out_alu_control), 64'(LUI));
    chk("lui_illegal", 64'(out_illegal), 64'd0);
    chk("lui_pc", 64'(out_pc), 64'h100);

    // AUIPC x1, 1 (accept + pop in ONE)
    present(32'h00001097, 32'h104); step();
    chk("auipc_rd", 64'(out_rd), 64'd1);
    chk("auipc_imm", 64'(out_imm), 64'h1000);
    chk("auipc_alu", 64'(out_alu_control), 64'(AUIPC));

    // beq -4
    present(32'hFE000EE3, 32'h108); step();
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(out_fmt), 64'(FMT_B));
    chk("beq_rd", 64'(out_rd), 64'd0);
    chk("beq_alu", 64'(out_alu_control), 64'(ALU_NOP));

    // sw x2, 8(x1)
    present(32'h0020A423, 32'h10C); step();
    chk("sw_imm", 64'(out_imm), 64'd8);
    chk("sw_fmt", 64'(out_fmt), 64'(FMT_S));
    chk("sw_rd", 64'(out_rd), 64'd0);

    // unknown opcode
    present(32'h0000007F, 32'h110); step();
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_fmt", 64'(out_fmt), 64'(FMT_NONE));
    chk("ill_imm", 64'(out_imm), 64'd0);
    chk("ill_rd", 64'(out_rd), 64'd0);

    in_valid = 1'b0; step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // 64-bit instance
    in_valid64 = 1'b1; in_instr64 = 32'h800000B7; in_pc64 = 64'h1_0000_0000; step();
    chk("x64_lui_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("x64_lui_pc", out_pc64, 64'h1_0000_0000);
    in_instr64 = 32'hFFF00093; step();
    chk("x64_addi_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("x64_addi_fmt", 64'(out_fmt64), 64'(FMT_I));
    chk("x64_addi_rd", 64'(out_rd64), 64'd1);
    in_valid64 = 1'b0;

    // Backpressure: A held, B to skid, C stalled
    out_ready = 1'b0;
    present(32'h00500113, 32'h200); step();
    chk("bp_a_rd", 64'(out_rd), 64'd2);
    chk("bp_a_inrdy", 64'(in_ready), 64'd1);
    present(32'h00600193, 32'h204); step();
    chk("bp_full_inrdy", 64'(in_ready), 64'd0);
    chk("bp_hold_a", 64'(out_rd), 64'd2);
    present(32'h00700213, 32'h208); step();
    chk("bp_stall_inrdy", 64'(in_ready), 64'd0);
    chk("bp_stall_a_imm", 64'(out_imm), 64'd5);
    out_ready = 1'b1;
    chk("bp_emit_a", 64'(out_rd), 64'd2);
    step();
    chk("bp_emit_b", 64'(out_rd), 64'd3);
    chk("bp_emit_b_pc", 64'(out_pc), 64'h204);
    chk("bp_emit_b_inrdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_emit_c", 64'(out_rd), 64'd4);
    chk("bp_emit_c_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush in FULL with input presented
    out_ready = 1'b0;
    present(32'h00800293, 32'h300); step();
    present(32'h00900313, 32'h304); step();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    present(32'h00A00393, 32'h308); step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_inrdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1; step();
    chk("fl_nothing", 64'(out_valid), 64'd0);

    // Flush in ONE with in_ready=1: the input is still dropped
    out_ready = 1'b0;
    present(32'h00B00413, 32'h30C); step();
    flush = 1'b1;
    present(32'h00C00493, 32'h310); step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_valid", 64'(out_valid), 64'd0);
    step();
    chk("fl1_dropped", 64'(out_valid), 64'd0);

    // Mid-stream reset in ONE
    present(32'h123450B7, 32'h400); step();
    chk("mr_one", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    present(32'h00001097, 32'h404); step();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_inrdy", 64'(in_ready), 64'd1);
    chk("mr_rd", 64'(out_rd), 64'd0);
    chk("mr_imm", 64'(out_imm), 64'd0);
    chk("mr_fmt", 64'(out_fmt), 64'd0);
    chk("mr_alu", 64'(out_alu_control), 64'(ALU_NOP));
    chk("mr_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    present(32'h00001097, 32'h500); step();
    in_valid = 1'b0;
    chk("mr_after_valid", 64'(out_valid), 64'd1);
    chk("mr_after_imm", 64'(out_imm), 64'h1000);
    chk("mr_after_pc", 64'(out_pc), 64'h500);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/decode_imm_stage.md
# decode_imm_stage

Registered, flow-controlled immediate-decode stage sitting between instruction fetch and the execute-stage ALU. It is the successor to the combinational upper-immediate decoder. It decodes rd, the format-correct sign-extended immediate and the ALU control code for all RV base immediate formats (U, J, I, S, B) at a parametrised datapath width. Instructions flow through a valid/ready handshake backed by a two-entry skid buffer, so `in_ready` is a registered signal. Recognised opcodes are LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, STORE and BRANCH.

## Interface
Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 and 64.
- ALU_CTRL_W, 5, width of ALU control code.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals NOT skid-entry-occupied.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of instruction.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts.
- out_rd  out  5  destination register.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format: NONE=0, U=1, J=2, I=3, S=4, B=5.
- out_alu_control  out  ALU_CTRL_W  LUI, AUIPC or ALU_NOP.
- out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11.
- out_pc  out  XLEN  PC passed through.

## Operation
- Decode is combinational on `in_instr`. The result is captured on acceptance, i.e. when `in_valid && in_ready` at a rising edge.
- Opcode map:
  - 0x37: U, LUI.
  - 0x17: U, AUIPC.
  - 0x6F: J.
  - 0x67, 0x03, 0x13: I.
  - 0x23: S.
  - 0x63: B.
  - Any other opcode: fmt NONE, illegal=1, imm=0, rd=0.
- `out_alu_control` is ALU_NOP for every opcode except 0x37 and 0x17.
- Immediates, all sign-extended from instr[31] to XLEN:
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- `out_rd` is instr[11:7] for U, J and I formats, and 0 for S, B and NONE.
- Occupancy states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: output register valid, in_ready=1.
  - FULL: output and skid registers valid, in_ready=0.
- Transitions, where acc = accept and pop = out_valid && out_ready:
  - EMPTY + acc -> ONE.
  - ONE + acc, no pop -> FULL; the new item goes to skid.
  - ONE + pop, no acc -> EMPTY.
  - ONE + acc + pop -> ONE, with the new item in the output register.
  - FULL + pop -> ONE, with skid moved to the output register.
  - FULL never accepts, because in_ready=0.
- Order is strictly preserved. The output fields hold stable while out_valid=1 and out_ready=0.
- Flush has priority over everything. The next state is EMPTY and an input presented in the flush cycle is dropped, even if in_ready=1. A pop in the flush cycle still counts as consumed downstream.
- Reset: occupancy EMPTY, out_valid=0, in_ready=1. All data outputs are 0: rd, imm, fmt, alu_control=ALU_NOP, illegal, pc.

## Timing
- Latency 1: an item accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready is a register output with no combinational path from out_ready. out_valid and all data outputs are also register outputs.
- Reset mid-stream: state returns to EMPTY on the reset edge with nothing emitted afterwards. The handshake is ignored while rst_n=0.

## Structure
- Shared package `decode_pkg`:
  - Opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH.
  - imm_fmt_e enum.
  - ALU control codes LUI, AUIPC, ALU_NOP, identical in value to the processor_defines values.
  - A decoded-instruction struct type parametrised by XLEN, containing rd, imm, fmt, alu_control, illegal and pc.
- One sub-module, `imm_decode_comb`: pure combinational instr -> decoded struct. It is instantiated once, in front of the skid buffer.

## Test plan
- XLEN=32, accept 0x123450B7 -> next cycle out_rd=1, imm=0x12345000, fmt=U, alu_control=LUI, illegal=0. Repeat with 0x00001097 -> rd=1, imm=0x00001000, alu_control=AUIPC.
- XLEN=64, accept 0x800000B7 -> imm=0xFFFFFFFF80000000; accept 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFFFFFFFFFF, fmt=I, rd=1.
- Accept 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=B, rd=0. Accept 0x0000007F -> illegal=1, fmt=NONE, imm=0.
- Backpressure: hold out_ready=0 and stream three instructions A, B, C -> A is held on the output, B goes to skid, in_ready drops after the second accept and C is stalled. Release out_ready -> A, B, C emerge in order on consecutive cycles.
- Flush in the FULL state, with in_valid=1 in the same cycle -> out_valid=0 and in_ready=1 next cycle, and the presented input never appears.
- Assert rst_n=0 for one cycle in the ONE state -> out_valid=0, in_ready=1, all data outputs 0. A subsequent accept works normally.
